// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan codes and FSM state encoding for the PS/2 sensor key controller.
package ps2_pkg;
  localparam logic [7:0] SC_T     = 8'h2C;
  localparam logic [7:0] SC_H     = 8'h33;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_e;
endpackage

// File: rtl/ps2_timeout_ctr.sv
// ps2_timeout_ctr: counts idle cycles while enabled; expired flags the last allowed cycle.
module ps2_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int CNT_W          = 22
) (
  input  logic CLK_clk_i,
  input  logic RST_rst_n_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge CLK_clk_i or negedge RST_rst_n_i)
    if (!RST_rst_n_i) cnt <= '0;
    else              cnt <= (clear || !enable) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ps2_sensor_key_ctrl.sv
// ps2_sensor_key_ctrl: turns PS/2 make/break scan codes into held sensor-select levels.
module ps2_sensor_key_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int CNT_W          = 22
) (
  input  logic       CLK_clk_i,
  input  logic       RST_rst_n_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_tick_i,
  input  logic       clr_err_i,
  output logic       Sensor_Temp_o,
  output logic       Sensor_Humo_o,
  output logic       key_evt_o,
  output logic       timeout_err_o
);
  ps2_state_e st, st_n;
  logic held_t, held_h, held_a, held_t_n, held_h_n, held_a_n;
  logic expired, to_hit;
  logic is_t, is_h, is_a;
  assign is_t = rx_data_i == SC_T;
  assign is_h = rx_data_i == SC_H;
  assign is_a = rx_data_i == SC_A;
  ps2_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_to (
    .CLK_clk_i  (CLK_clk_i),
    .RST_rst_n_i(RST_rst_n_i),
    .clear      (rx_done_tick_i || (st_n != st)),
    .enable     (st != IDLE),
    .expired    (expired)
  );
  // A byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    st_n     = st;
    held_t_n = held_t;
    held_h_n = held_h;
    held_a_n = held_a;
    to_hit   = 1'b0;
    if (rx_done_tick_i)
      case (st)
        IDLE: begin
          st_n     = (rx_data_i == SC_BREAK) ? BRK : (rx_data_i == SC_EXT) ? EXT : IDLE;
          held_t_n = held_t | is_t;
          held_h_n = held_h | is_h;
          held_a_n = held_a | is_a;
        end
        BRK: begin
          st_n     = IDLE;
          held_t_n = held_t & ~is_t;
          held_h_n = held_h & ~is_h;
          held_a_n = held_a & ~is_a;
        end
        EXT:     st_n = (rx_data_i == SC_BREAK) ? EXT_BRK : IDLE;
        EXT_BRK: st_n = IDLE;
      endcase
    else if (expired) begin
      st_n   = IDLE;
      to_hit = 1'b1;
    end
  end
  always_ff @(posedge CLK_clk_i or negedge RST_rst_n_i)
    if (!RST_rst_n_i) begin
      st            <= IDLE;
      held_t        <= 1'b0;
      held_h        <= 1'b0;
      held_a        <= 1'b0;
      Sensor_Temp_o <= 1'b0;
      Sensor_Humo_o <= 1'b0;
      key_evt_o     <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      st            <= st_n;
      held_t        <= held_t_n;
      held_h        <= held_h_n;
      held_a        <= held_a_n;
      Sensor_Temp_o <= held_t_n | held_a_n;
      Sensor_Humo_o <= held_h_n | held_a_n;
      key_evt_o     <= (~held_t & held_t_n) | (~held_h & held_h_n) | (~held_a & held_a_n);
      timeout_err_o <= to_hit | (timeout_err_o & ~clr_err_i);
    end
endmodule

// File: tb/tb_ps2_sensor_key_ctrl.sv
// tb_ps2_sensor_key_ctrl: directed checks of make/break tracking, typematic, extended filter and timeout.
module tb_ps2_sensor_key_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_tick = 1'b0;
  logic       clr_err = 1'b0;
  logic       temp, humo, evt, err;
  int         n_pass = 0;
  int         n_chk = 0;
  int         evt_cnt = 0;
  int         base;

  ps2_sensor_key_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .CLK_clk_i     (clk),
    .RST_rst_n_i   (rst_n),
    .rx_data_i     (rx_data),
    .rx_done_tick_i(rx_tick),
    .clr_err_i     (clr_err),
    .Sensor_Temp_o (temp),
    .Sensor_Humo_o (humo),
    .key_evt_o     (evt),
    .timeout_err_o (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (evt) evt_cnt <= evt_cnt + 1;

  // Called at a falling edge; returns at the next falling edge with outputs updated.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_tick = 1'b1;
    @(negedge clk);
    rx_tick = 1'b0;
  endtask

  task automatic test_reset;
    n_chk++; if (temp !== 1'b0) $display("FAIL reset_temp got %b want 0", temp); else n_pass++;
    n_chk++; if (humo !== 1'b0) $display("FAIL reset_humo got %b want 0", humo); else n_pass++;
    n_chk++; if (evt !== 1'b0) $display("FAIL reset_evt got %b want 0", evt); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    send_byte(8'hF0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (temp !== 1'b0) $display("FAIL reset_mid_temp got %b want 0", temp); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    rx_data = 8'h2C;
    @(negedge clk);
    n_chk++; if (temp !== 1'b0) $display("FAIL no_strobe_temp got %b want 0", temp); else n_pass++;
    send_byte(8'h2C);
    n_chk++; if (temp !== 1'b1) $display("FAIL reset_mid_brk_temp got %b want 1", temp); else n_pass++;
    send_byte(8'hF0);
    send_byte(8'h2C);
    n_chk++; if (temp !== 1'b0) $display("FAIL reset_cleanup_temp got %b want 0", temp); else n_pass++;
  endtask

  task automatic test_make_break;
    send_byte(8'h2C);
    n_chk++; if (temp !== 1'b1) $display("FAIL mb_make_temp got %b want 1", temp); else n_pass++;
    n_chk++; if (evt !== 1'b1) $display("FAIL mb_evt_high got %b want 1", evt); else n_pass++;
    n_chk++; if (humo !== 1'b0) $display("FAIL mb_make_humo got %b want 0", humo); else n_pass++;
    send_byte(8'hF0);
    n_chk++; if (evt !== 1'b0) $display("FAIL mb_evt_single got %b want 0", evt); else n_pass++;
    n_chk++; if (temp !== 1'b1) $display("FAIL mb_f0_temp got %b want 1", temp); else n_pass++;
    send_byte(8'h2C);
    n_chk++; if (temp !== 1'b0) $display("FAIL mb_break_temp got %b want 0", temp); else n_pass++;
    n_chk++; if (humo !== 1'b0) $display("FAIL mb_break_humo got %b want 0", humo); else n_pass++;
  endtask

  task automatic test_typematic;
    base = evt_cnt;
    repeat (5) send_byte(8'h33);
    @(negedge clk);
    n_chk++; if (humo !== 1'b1) $display("FAIL typ_humo got %b want 1", humo); else n_pass++;
    n_chk++; if (evt_cnt - base !== 1) $display("FAIL typ_pulses got %0d want 1", evt_cnt - base); else n_pass++;
    send_byte(8'hF0);
    send_byte(8'h33);
    n_chk++; if (humo !== 1'b0) $display("FAIL typ_release_humo got %b want 0", humo); else n_pass++;
  endtask

  task automatic test_overlap;
    base = evt_cnt;
    send_byte(8'h1C);
    n_chk++; if (temp !== 1'b1 || humo !== 1'b1) $display("FAIL ovl_a got %b%b want 11", temp, humo); else n_pass++;
    send_byte(8'h2C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    @(negedge clk);
    n_chk++; if (temp !== 1'b1) $display("FAIL ovl_temp got %b want 1", temp); else n_pass++;
    n_chk++; if (humo !== 1'b0) $display("FAIL ovl_humo got %b want 0", humo); else n_pass++;
    n_chk++; if (evt_cnt - base !== 2) $display("FAIL ovl_pulses got %0d want 2", evt_cnt - base); else n_pass++;
    send_byte(8'hF0);
    send_byte(8'h2C);
    n_chk++; if (temp !== 1'b0) $display("FAIL ovl_cleanup_temp got %b want 0", temp); else n_pass++;
  endtask

  task automatic test_extended;
    base = evt_cnt;
    send_byte(8'hE0);
    send_byte(8'h2C);
    @(negedge clk);
    n_chk++; if (temp !== 1'b0 || humo !== 1'b0) $display("FAIL ext_outs got %b%b want 00", temp, humo); else n_pass++;
    n_chk++; if (evt_cnt - base !== 0) $display("FAIL ext_pulses got %0d want 0", evt_cnt - base); else n_pass++;
    send_byte(8'h2C);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h2C);
    n_chk++; if (temp !== 1'b1) $display("FAIL ext_brk_temp got %b want 1", temp); else n_pass++;
    send_byte(8'hF0);
    send_byte(8'hF0);
    send_byte(8'h2C);
    n_chk++; if (temp !== 1'b1) $display("FAIL f0f0_temp got %b want 1", temp); else n_pass++;
    send_byte(8'hF0);
    send_byte(8'h2C);
    n_chk++; if (temp !== 1'b0) $display("FAIL ext_cleanup_temp got %b want 0", temp); else n_pass++;
  endtask

  task automatic test_timeout;
    send_byte(8'hF0);
    repeat (15) @(negedge clk);
    n_chk++; if (err !== 1'b0) $display("FAIL to_early_err got %b want 0", err); else n_pass++;
    @(negedge clk);
    n_chk++; if (err !== 1'b1) $display("FAIL to_expire_err got %b want 1", err); else n_pass++;
    send_byte(8'h2C);
    n_chk++; if (temp !== 1'b1) $display("FAIL to_idle_temp got %b want 1", temp); else n_pass++;
    n_chk++; if (err !== 1'b1) $display("FAIL to_sticky_err got %b want 1", err); else n_pass++;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_chk++; if (err !== 1'b0) $display("FAIL to_clr_err got %b want 0", err); else n_pass++;
    send_byte(8'hF0);
    repeat (15) @(negedge clk);
    send_byte(8'h2C);
    n_chk++; if (err !== 1'b0) $display("FAIL to_race_err got %b want 0", err); else n_pass++;
    n_chk++; if (temp !== 1'b0) $display("FAIL to_race_temp got %b want 0", temp); else n_pass++;
    repeat (20) @(negedge clk);
    n_chk++; if (err !== 1'b0) $display("FAIL to_idle_no_err got %b want 0", err); else n_pass++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset_pre: begin end
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_make_break;
    test_typematic;
    test_overlap;
    test_extended;
    test_timeout;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
